// File: rtl/bpsk_modulator.sv
// Serial BPSK modulator: streams a 16-bit word MSB-first as a 16-sample sine
// carrier per bit, inverting the carrier for 0 bits. The word repeats until reloaded.
module bpsk_modulator #(
  parameter int unsigned CYCLES_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [15:0]        data,
  output logic signed [15:0] bpsk
);

  localparam logic [7:0] LAST_CYC = 8'(CYCLES_PER_BIT - 1);

  logic [15:0]        data_reg;
  logic [3:0]         phase;
  logic [3:0]         bit_idx;
  logic [7:0]         cyc_cnt;
  logic signed [15:0] lut_val;

  always_comb begin
    lut_val = '0;
    case (phase)
      4'd0:  lut_val = 16'sd0;
      4'd1:  lut_val = 16'sd12539;
      4'd2:  lut_val = 16'sd23170;
      4'd3:  lut_val = 16'sd30273;
      4'd4:  lut_val = 16'sd32767;
      4'd5:  lut_val = 16'sd30273;
      4'd6:  lut_val = 16'sd23170;
      4'd7:  lut_val = 16'sd12539;
      4'd8:  lut_val = 16'sd0;
      4'd9:  lut_val = -16'sd12539;
      4'd10: lut_val = -16'sd23170;
      4'd11: lut_val = -16'sd30273;
      4'd12: lut_val = -16'sd32767;
      4'd13: lut_val = -16'sd30273;
      4'd14: lut_val = -16'sd23170;
      4'd15: lut_val = -16'sd12539;
      default: lut_val = '0;
    endcase
  end

  // Unreset on purpose: a word loaded while rst is high survives reset release.
  always_ff @(posedge clk) begin
    if (ld) data_reg <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpsk    <= '0;
      phase   <= '0;
      bit_idx <= 4'd15;
      cyc_cnt <= '0;
    end else if (ld) begin
      bpsk    <= '0;
      phase   <= '0;
      bit_idx <= 4'd15;
      cyc_cnt <= '0;
    end else begin
      bpsk  <= data_reg[bit_idx] ? lut_val : -lut_val;
      phase <= phase + 4'd1;
      // Bit changes only at the end of a carrier period, i.e. at a zero crossing.
      if (phase == 4'd15) begin
        if (cyc_cnt == LAST_CYC) begin
          cyc_cnt <= '0;
          bit_idx <= bit_idx - 4'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Bench for bpsk_modulator: two instances (1 and 2 carrier periods per bit) share
// stimulus and are checked against a sample-index model of the modulation.
module tb_bpsk_modulator;

  logic               clk;
  logic               rst;
  logic               ld;
  logic [15:0]        data;
  logic signed [15:0] bpsk1;
  logic signed [15:0] bpsk2;

  int tests = 0;
  int fails = 0;

  // Model state: word being sent and sample count since the last restart.
  logic [15:0] mdata;
  int          n;

  int lut [16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                   0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

  bpsk_modulator #(.CYCLES_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .ld(ld), .data(data), .bpsk(bpsk1)
  );

  bpsk_modulator #(.CYCLES_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .ld(ld), .data(data), .bpsk(bpsk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(int idx, int cpb);
    int bit_no;
    int ph;
    int v;
    bit_no = (idx / (16 * cpb)) % 16;
    ph     = idx % 16;
    v      = mdata[15 - bit_no] ? lut[ph] : -lut[ph];
    return 16'(v);
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then check.
  task automatic step(string tag);
    logic [15:0] e1;
    logic [15:0] e2;
    @(posedge clk);
    if (ld) mdata = data;
    if (rst || ld) begin
      e1 = '0;
      e2 = '0;
      n  = 0;
    end else begin
      e1 = model(n, 1);
      e2 = model(n, 2);
      n++;
    end
    #1;
    check({tag, "_c1"}, bpsk1, e1);
    check({tag, "_c2"}, bpsk2, e2);
  endtask

  task automatic load_word(logic [15:0] w);
    data = w;
    ld   = 1'b1;
    step("load");
    ld   = 1'b0;
    data = 16'($urandom);
  endtask

  task automatic run(string tag, int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    rst   = 1'b1;
    ld    = 1'b0;
    data  = 16'($urandom);
    mdata = '0;
    n     = 0;

    run("reset_hold", 5);

    // Preload during reset; rst drops between edges.
    data = 16'hAAAA;
    ld   = 1'b1;
    step("preload_edge");
    ld   = 1'b0;
    data = 16'h5555;
    run("reset_after_preload", 2);
    rst = 1'b0;
    run("aaaa_wrap", 600);

    // Mid-stream reload to all zeros: carrier permanently inverted.
    load_word(16'hAAAA);
    run("pre_reload", 40);
    load_word(16'h0000);
    run("all_zero", 100);

    load_word(16'hFFFF);
    run("all_one", 64);

    load_word(16'h8000);
    run("msb_only", 530);

    // Asynchronous reset mid-stream: output clears without an edge.
    rst = 1'b1;
    #1;
    n = 0;
    check("async_rst_c1", bpsk1, 16'h0000);
    check("async_rst_c2", bpsk2, 16'h0000);
    ld   = 1'b1;
    data = 16'h1234;
    step("ld_during_rst");
    ld = 1'b0;
    run("rst_hold", 2);
    rst = 1'b0;
    run("post_rst_1234", 100);

    for (int r = 0; r < 8; r++) begin
      load_word(16'($urandom));
      run("rand_run", $urandom_range(20, 300));
      if ($urandom_range(0, 1) == 1) begin
        rst = 1'b1;
        #2;
        n = 0;
        check("rand_async_rst_c1", bpsk1, 16'h0000);
        check("rand_async_rst_c2", bpsk2, 16'h0000);
        run("rand_rst_hold", $urandom_range(1, 3));
        rst = 1'b0;
        run("rand_after_rst", $urandom_range(10, 80));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
